// File: rtl/product_chain_pkg.sv
// ---------------------------------------------------------------------------
// product_chain_pkg
// Shared constants and types for the six-factor Q15.11 product chain.
//   W        : operand/result width (unsigned Q15.11)
//   FRAC     : fractional bits of every operand and of the result
//   ONE_Q11  : the value 1.0 in Q15.11
//   SAT_MAX  : largest representable result, used when saturating
//   NUM_STEPS: number of factors folded into one product
//   state_e  : controller states
// ---------------------------------------------------------------------------
package product_chain_pkg;

  localparam int W         = 26;
  localparam int FRAC      = 11;
  localparam int ONE_Q11   = 2048;
  localparam logic [W-1:0] SAT_MAX = {W{1'b1}};
  localparam int NUM_STEPS = 6;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

endpackage

// File: rtl/q11_mul_sat.sv
// ---------------------------------------------------------------------------
// q11_mul_sat
// Combinational fixed-point multiply with round-half-up and saturation.
//   a, b    : unsigned Q15.11 factors (W bits)
//   product : round(a*b) in Q15.11, clamped to all-ones on overflow
//   sat     : high when the clamp was applied
// ---------------------------------------------------------------------------
module q11_mul_sat #(
  parameter int W    = 26,
  parameter int FRAC = 11
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] product,
  output logic         sat
);

  // Half an output LSB, added before truncation so ties round upward.
  localparam logic [2*W-1:0] HALF = {{(2*W-1){1'b0}}, 1'b1} << (FRAC - 1);

  logic [2*W-1:0] fullProd;
  logic [2*W-1:0] rounded;
  logic [2*W-1:0] shifted;

  // The largest full product plus HALF still fits in 2W bits, so the
  // rounding addition cannot wrap.
  assign fullProd = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign rounded  = fullProd + HALF;
  assign shifted  = rounded >> FRAC;

  // Anything left above bit W-1 after the shift is out of range.
  assign sat     = |shifted[2*W-1:W];
  assign product = sat ? {W{1'b1}} : shifted[W-1:0];

endmodule

// File: rtl/product_chain.sv
// ---------------------------------------------------------------------------
// product_chain
// Multiplies six unsigned Q15.11 factors with one time-shared rounding,
// saturating multiplier; one factor is folded in per clock.
//   clk, rst_n        : clock, asynchronous active-low reset
//   mul_valid         : one-cycle request; multiplier_0..5 valid with it
//   multiplier_0..5   : factors; a zero factor counts as 1.0
//   busy              : a product is in progress
//   exp_valid         : one-cycle pulse, exp_result/exp_sat are new
//   exp_result        : final product, held until the next one
//   exp_sat           : saturation happened somewhere in that product
//   in_drop           : one-cycle pulse, a request arrived while busy
// ---------------------------------------------------------------------------
module product_chain #(
  parameter int W    = product_chain_pkg::W,
  parameter int FRAC = product_chain_pkg::FRAC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mul_valid,
  input  logic [W-1:0] multiplier_0,
  input  logic [W-1:0] multiplier_1,
  input  logic [W-1:0] multiplier_2,
  input  logic [W-1:0] multiplier_3,
  input  logic [W-1:0] multiplier_4,
  input  logic [W-1:0] multiplier_5,
  output logic         busy,
  output logic         exp_valid,
  output logic [W-1:0] exp_result,
  output logic         exp_sat,
  output logic         in_drop
);

  import product_chain_pkg::*;

  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [2:0]   LAST_IDX = 3'(NUM_STEPS - 1);

  state_e       state_q, state_d;
  logic [W-1:0] ops_q [NUM_STEPS];
  logic [W-1:0] ops_d [NUM_STEPS];
  logic [W-1:0] acc_q, acc_d;
  logic [2:0]   stepIdx_q, stepIdx_d;
  logic         satSticky_q, satSticky_d;
  logic         expValid_q, expValid_d;
  logic [W-1:0] expResult_q, expResult_d;
  logic         expSat_q, expSat_d;
  logic         inDrop_q, inDrop_d;

  logic [W-1:0] opSel;
  logic [W-1:0] mulB;
  logic [W-1:0] stepProd;
  logic         stepSat;

  // A zero factor marks an unused stage and is replaced by 1.0 so the
  // step still takes its cycle without changing the accumulator.
  assign opSel = ops_q[stepIdx_q];
  assign mulB  = (opSel == '0) ? ONE : opSel;

  q11_mul_sat #(
    .W   (W),
    .FRAC(FRAC)
  ) uMul (
    .a      (acc_q),
    .b      (mulB),
    .product(stepProd),
    .sat    (stepSat)
  );

  // Next-state logic: capture the request in IDLE, fold one factor per
  // cycle in CALC, and publish the result on the last step.
  always_comb begin
    state_d     = state_q;
    ops_d       = ops_q;
    acc_d       = acc_q;
    stepIdx_d   = stepIdx_q;
    satSticky_d = satSticky_q;
    expValid_d  = 1'b0;
    expResult_d = expResult_q;
    expSat_d    = expSat_q;
    inDrop_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mul_valid) begin
          ops_d[0]    = multiplier_0;
          ops_d[1]    = multiplier_1;
          ops_d[2]    = multiplier_2;
          ops_d[3]    = multiplier_3;
          ops_d[4]    = multiplier_4;
          ops_d[5]    = multiplier_5;
          acc_d       = ONE;
          stepIdx_d   = 3'd0;
          satSticky_d = 1'b0;
          state_d     = CALC;
        end
      end
      CALC: begin
        acc_d       = stepProd;
        satSticky_d = satSticky_q | stepSat;
        stepIdx_d   = stepIdx_q + 3'd1;
        // Requests during a product are discarded, only reported.
        inDrop_d    = mul_valid;
        if (stepIdx_q == LAST_IDX) begin
          state_d     = IDLE;
          stepIdx_d   = 3'd0;
          expValid_d  = 1'b1;
          expResult_d = stepProd;
          expSat_d    = satSticky_q | stepSat;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any product in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < NUM_STEPS; i++) ops_q[i] <= '0;
      acc_q       <= '0;
      stepIdx_q   <= 3'd0;
      satSticky_q <= 1'b0;
      expValid_q  <= 1'b0;
      expResult_q <= '0;
      expSat_q    <= 1'b0;
      inDrop_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < NUM_STEPS; i++) ops_q[i] <= ops_d[i];
      acc_q       <= acc_d;
      stepIdx_q   <= stepIdx_d;
      satSticky_q <= satSticky_d;
      expValid_q  <= expValid_d;
      expResult_q <= expResult_d;
      expSat_q    <= expSat_d;
      inDrop_q    <= inDrop_d;
    end
  end

  assign busy       = (state_q == CALC);
  assign exp_valid  = expValid_q;
  assign exp_result = expResult_q;
  assign exp_sat    = expSat_q;
  assign in_drop    = inDrop_q;

endmodule

// File: tb/tb_product_chain.sv
// ---------------------------------------------------------------------------
// tb_product_chain
// Self-checking bench for product_chain: fixed vector table, hand-written
// drop and mid-product reset sequences, and random products compared with
// an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_product_chain;

  localparam int W = 26;
  localparam longint unsigned MAXV = 64'd67108863;

  typedef logic [5:0][W-1:0] ops_t;

  typedef struct {
    ops_t         ops;
    logic [W-1:0] expRes;
    logic         expSat;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         mul_valid;
  logic [W-1:0] multiplier_0, multiplier_1, multiplier_2;
  logic [W-1:0] multiplier_3, multiplier_4, multiplier_5;
  logic         busy;
  logic         exp_valid;
  logic [W-1:0] exp_result;
  logic         exp_sat;
  logic         in_drop;

  int checks   = 0;
  int failures = 0;

  product_chain dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mul_valid   (mul_valid),
    .multiplier_0(multiplier_0),
    .multiplier_1(multiplier_1),
    .multiplier_2(multiplier_2),
    .multiplier_3(multiplier_3),
    .multiplier_4(multiplier_4),
    .multiplier_5(multiplier_5),
    .busy        (busy),
    .exp_valid   (exp_valid),
    .exp_result  (exp_result),
    .exp_sat     (exp_sat),
    .in_drop     (in_drop)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some wait escapes its bound.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ops_t mk(input logic [W-1:0] o0, o1, o2, o3, o4, o5);
    return {o5, o4, o3, o2, o1, o0};
  endfunction

  // Reference: value-level arithmetic on real-number-style rules.
  function automatic void refModel(input ops_t ops, output logic [W-1:0] res,
                                   output logic sat);
    longint unsigned acc, f, p;
    acc = 64'd2048;
    sat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      f = (ops[i] == '0) ? 64'd2048 : 64'(ops[i]);
      p = (acc * f + 64'd1024) / 64'd2048;
      if (p > MAXV) begin
        p   = MAXV;
        sat = 1'b1;
      end
      acc = p;
    end
    res = acc[W-1:0];
  endfunction

  function automatic logic [W-1:0] randOp();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return W'($urandom_range(1024, 4096));
      2:       return W'($urandom_range(1, 3000));
      default: return W'($urandom_range(0, 67108863));
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Called on a falling edge: presents the request for one clock and
  // returns on the falling edge after the capturing rising edge.
  task automatic applyStimulus(input ops_t ops);
    multiplier_0 = ops[0];
    multiplier_1 = ops[1];
    multiplier_2 = ops[2];
    multiplier_3 = ops[3];
    multiplier_4 = ops[4];
    multiplier_5 = ops[5];
    mul_valid    = 1'b1;
    @(negedge clk);
    mul_valid    = 1'b0;
  endtask

  // Counts falling edges until exp_valid is seen, bounded at 20.
  task automatic waitForResult(output int cycles);
    cycles = 0;
    while (!exp_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  vec_t         tbl [8];
  int           cyc;
  int           extra;
  logic [W-1:0] mRes;
  logic         mSat;
  ops_t         rOps;

  initial begin
    tbl[0] = '{mk(2048, 2048, 2048, 2048, 2048, 2048), 26'd2048, 1'b0};
    tbl[1] = '{mk(4096, 4096, 4096, 4096, 4096, 4096), 26'd131072, 1'b0};
    tbl[2] = '{mk(3, 1024, 0, 0, 0, 0), 26'd2, 1'b0};
    tbl[3] = '{mk(26'h2000000, 26'h2000000, 26'h2000000, 26'h2000000,
                  26'h2000000, 26'h2000000), 26'h3FFFFFF, 1'b1};
    tbl[4] = '{mk(26'h2000000, 26'h2000000, 1024, 0, 0, 0), 26'd33554432, 1'b1};
    tbl[5] = '{mk(26'h3FFFFFF, 0, 0, 0, 0, 0), 26'h3FFFFFF, 1'b0};
    tbl[6] = '{mk(1, 1024, 0, 0, 0, 0), 26'd1, 1'b0};
    tbl[7] = '{mk(1, 1, 1, 1, 1, 1), 26'd0, 1'b0};

    rst_n = 1'b0;
    mul_valid = 1'b0;
    multiplier_0 = '0; multiplier_1 = '0; multiplier_2 = '0;
    multiplier_3 = '0; multiplier_4 = '0; multiplier_5 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_exp_valid", 32'(exp_valid), 32'd0);
    checkOutput("reset_exp_result", 32'(exp_result), 32'd0);
    checkOutput("reset_exp_sat", 32'(exp_sat), 32'd0);
    checkOutput("reset_in_drop", 32'(in_drop), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table: latency, value and saturation of each product.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].ops);
      checkOutput($sformatf("tbl%0d_busy", i), 32'(busy), 32'd1);
      waitForResult(cyc);
      checkOutput($sformatf("tbl%0d_latency", i), 32'(cyc + 1), 32'd7);
      checkOutput($sformatf("tbl%0d_result", i), 32'(exp_result), 32'(tbl[i].expRes));
      checkOutput($sformatf("tbl%0d_sat", i), 32'(exp_sat), 32'(tbl[i].expSat));
      checkOutput($sformatf("tbl%0d_busy_done", i), 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_pulse", i), 32'(exp_valid), 32'd0);
      checkOutput($sformatf("tbl%0d_hold", i), 32'(exp_result), 32'(tbl[i].expRes));
    end

    // Request three cycles into a product is dropped and reported.
    applyStimulus(mk(4096, 4096, 4096, 4096, 4096, 4096));
    @(negedge clk);
    @(negedge clk);
    multiplier_0 = 26'd3;
    multiplier_1 = 26'd5;
    mul_valid    = 1'b1;
    @(negedge clk);
    mul_valid    = 1'b0;
    checkOutput("drop_pulse", 32'(in_drop), 32'd1);
    @(negedge clk);
    checkOutput("drop_pulse_end", 32'(in_drop), 32'd0);
    waitForResult(cyc);
    checkOutput("drop_latency", 32'(cyc), 32'd2);
    checkOutput("drop_result", 32'(exp_result), 32'd131072);
    checkOutput("drop_sat", 32'(exp_sat), 32'd0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (exp_valid) extra++;
    end
    checkOutput("drop_no_second", 32'(extra), 32'd0);

    // Saturating product leaves nonzero outputs for the reset to clear.
    applyStimulus(tbl[3].ops);
    waitForResult(cyc);
    checkOutput("presat_sat", 32'(exp_sat), 32'd1);
    @(negedge clk);

    // Reset asserted mid-product clears outputs at once and aborts it.
    applyStimulus(mk(4096, 4096, 4096, 4096, 4096, 4096));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_exp_valid", 32'(exp_valid), 32'd0);
    checkOutput("midrst_exp_result", 32'(exp_result), 32'd0);
    checkOutput("midrst_exp_sat", 32'(exp_sat), 32'd0);
    checkOutput("midrst_in_drop", 32'(in_drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (exp_valid) extra++;
    end
    checkOutput("midrst_no_result", 32'(extra), 32'd0);
    applyStimulus(tbl[0].ops);
    waitForResult(cyc);
    checkOutput("postrst_latency", 32'(cyc + 1), 32'd7);
    checkOutput("postrst_result", 32'(exp_result), 32'd2048);
    @(negedge clk);

    // Random products, each new request issued in the exp_valid cycle.
    rOps = '0;
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 6; j++) rOps[j] = randOp();
      refModel(rOps, mRes, mSat);
      applyStimulus(rOps);
      waitForResult(cyc);
      checkOutput($sformatf("rnd%0d_latency", n), 32'(cyc + 1), 32'd7);
      checkOutput($sformatf("rnd%0d_result", n), 32'(exp_result), 32'(mRes));
      checkOutput($sformatf("rnd%0d_sat", n), 32'(exp_sat), 32'(mSat));
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/product_chain.md
PRODUCT_CHAIN -- requirements
Module: product_chain

Interface
REQ-001 SHALL have parameter W, default 26, meaning operand/result width in unsigned Q15.11.
REQ-002 SHALL have parameter FRAC, default 11, meaning fractional bits of all operands and result.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous active-low.
REQ-005 SHALL have port mul_valid  input  1  single-cycle pulse; operands valid this cycle.
REQ-006 SHALL have ports multiplier_0 .. multiplier_5  input  W each  six unsigned Q15.11 factors.
REQ-007 SHALL have port busy  output  1  high while a product is in progress.
REQ-008 SHALL have port exp_valid  output  1  single-cycle pulse; exp_result/exp_sat valid.
REQ-009 SHALL have port exp_result  output  W  product of the six factors, Q15.11.
REQ-010 SHALL have port exp_sat  output  1  saturation occurred during this product.
REQ-011 SHALL have port in_drop  output  1  single-cycle pulse; a mul_valid was ignored.

Function
REQ-012 SHALL implement states IDLE, CALC; IDLE -> CALC on mul_valid; CALC -> IDLE after sixth update.
REQ-013 SHALL, in IDLE on mul_valid, capture all six operands, set acc = 1.0 (2048), step index = 0, sat flag = 0.
REQ-014 SHALL, each CALC cycle, compute acc <= rnd_sat(acc * op[idx]) and increment idx; idx 0..5 in order.
REQ-015 SHALL compute rnd_sat as: 2W-bit full product, add 2^(FRAC-1), shift right FRAC (round half up).
REQ-016 SHALL saturate any shifted value exceeding 2^W-1 to 2^W-1 and set the sticky sat flag.
REQ-017 SHALL treat an operand equal to zero as identity 1.0 (unused stage); step still consumes one cycle.
REQ-018 SHALL keep latency fixed: mul_valid sampled at edge k -> exp_valid high for exactly the cycle after edge k+6.
REQ-019 SHALL register exp_result and exp_sat at edge k+6 and hold them until the next result.
REQ-020 SHALL drive busy high from edge k to edge k+6 (low in the exp_valid cycle).
REQ-021 SHALL ignore mul_valid while busy, leave the computation unaffected, and pulse in_drop one cycle.
REQ-022 SHALL accept mul_valid in the exp_valid cycle (state already IDLE); back-to-back throughput one product per 7 cycles.
REQ-023 SHALL keep acc saturated once saturated; subsequent factors < 1.0 still scale the saturated value.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state IDLE, busy 0, exp_valid 0, in_drop 0, exp_result 0, exp_sat 0, acc 0, idx 0.
REQ-025 SHALL abort any in-progress product on reset; no exp_valid is produced for it.
REQ-026 SHALL ignore mul_valid in the first cycle after rst_n release only if it coincides with the release edge.

Structure
REQ-027 SHALL place W, FRAC, ONE_Q11 (2048), SAT_MAX (2^W-1), step count (6) and the state enumeration in a shared package.
REQ-028 SHALL use one combinational sub-module q11_mul_sat (a, b -> product, sat) for the multiply-round-saturate step.
REQ-029 SHALL use exactly one multiplier instance, time-shared across the six steps.

Verification
REQ-030 SHALL cover: all six operands 2048 -> exp_result 2048, exp_sat 0, exp_valid 7th cycle after mul_valid cycle.
REQ-031 SHALL cover: all six operands 4096 (2.0) -> exp_result 131072 (64.0), exp_sat 0.
REQ-032 SHALL cover: rounding, operands 3,1024,0,0,0,0 -> exp_result 2 (0.5*0.00146 rounded up), zeros as identity.
REQ-033 SHALL cover: operands all 2^25 -> exp_result 0x3FFFFFF, exp_sat 1.
REQ-034 SHALL cover: second mul_valid 3 cycles after first -> in_drop pulse, first result unchanged, no second exp_valid.
REQ-035 SHALL cover: rst_n asserted at CALC step 3 -> all outputs 0 immediately, no exp_valid; new mul_valid afterwards completes normally.
